// File: rtl/hp48_bus_ctrl_if.sv
// hp48_bus_ctrl_if: CPU-side bus and device-side signals of the HP48 bus controller.
interface hp48_bus_ctrl_if #(
    parameter int NUM_DEV = 3,
    parameter int ADDR_W  = 20
);
    logic [ADDR_W-1:0]    address;
    logic [3:0]           command;
    logic [4*NUM_DEV-1:0] dev_nibble_in;
    logic [NUM_DEV-1:0]   dev_sel;
    logic [3:0]           nibble_out;
    logic                 daisy_out;
    logic                 bus_error;
    modport master (
        output address, command, dev_nibble_in,
        input  dev_sel, nibble_out, daisy_out, bus_error
    );
    modport slave (
        input  address, command, dev_nibble_in,
        output dev_sel, nibble_out, daisy_out, bus_error
    );
endinterface

// File: rtl/hp48_bus_ctrl.sv
// hp48_bus_ctrl: Saturn-style bus controller with daisy-chained device configuration.
// Define HP48_BUS_ERR_EN to build the registered bus_error flag; otherwise bus_error is tied low.
module hp48_bus_ctrl #(
    parameter int NUM_DEV = 3,
    parameter int ADDR_W  = 20
) (
    input logic             strobe,
    input logic             reset,
    hp48_bus_ctrl_if.slave  bus
);
    localparam int NC = NUM_DEV - 1;
    localparam logic [3:0] CMD_PC_READ  = 4'h2;
    localparam logic [3:0] CMD_DP_READ  = 4'h3;
    localparam logic [3:0] CMD_DP_WRITE = 4'h5;
    localparam logic [3:0] CMD_CONFIG   = 4'h8;
    localparam logic [3:0] CMD_UNCONFIG = 4'h9;
    localparam logic [3:0] CMD_RESET    = 4'hC;
    localparam logic [NUM_DEV-1:0] FALLBACK = {1'b1, {NC{1'b0}}};

    typedef enum logic [1:0] {UNCFG, SIZED, CONFIGURED} dev_state_t;

    dev_state_t         st_q [NC];
    dev_state_t         st_d [NC];
    logic [ADDR_W-1:0]  mask_q [NC];
    logic [ADDR_W-1:0]  mask_d [NC];
    logic [ADDR_W-1:0]  base_q [NC];
    logic [ADDR_W-1:0]  base_d [NC];
    logic [NUM_DEV-1:0] sel_q, sel_d, match, sel_oh;
    logic [3:0]         nib;
    logic               daisy, done;

    always_comb begin
        match     = '0;
        match[NC] = 1'b1;
        daisy     = 1'b1;
        for (int i = 0; i < NC; i++) begin
            match[i] = st_q[i] == CONFIGURED && (bus.address & mask_q[i]) == base_q[i];
            daisy    = daisy & (st_q[i] == CONFIGURED);
        end
        sel_oh = match & -match;
    end

    always_comb begin
        st_d   = st_q;
        mask_d = mask_q;
        base_d = base_q;
        sel_d  = sel_q;
        done   = 1'b0;
        if (bus.command == CMD_PC_READ || bus.command == CMD_DP_READ || bus.command == CMD_DP_WRITE) begin
            sel_d = sel_oh;
        end else if (bus.command == CMD_CONFIG) begin
            // With every device configured the loop finds no target, so CONFIGURE is a no-op.
            for (int i = 0; i < NC; i++) begin
                if (!done && st_q[i] != CONFIGURED) begin
                    done = 1'b1;
                    if (st_q[i] == UNCFG) begin
                        st_d[i]   = SIZED;
                        mask_d[i] = bus.address;
                    end else begin
                        st_d[i]   = CONFIGURED;
                        base_d[i] = bus.address & mask_q[i];
                    end
                end
            end
        end else if (bus.command == CMD_UNCONFIG) begin
            for (int i = 0; i < NC; i++) begin
                if (!done && match[i]) begin
                    done    = 1'b1;
                    st_d[i] = UNCFG;
                end
            end
        end else if (bus.command == CMD_RESET) begin
            for (int i = 0; i < NC; i++) begin
                st_d[i]   = UNCFG;
                mask_d[i] = '0;
                base_d[i] = '0;
            end
        end
    end

    always_ff @(posedge strobe or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                st_q[i]   <= UNCFG;
                mask_q[i] <= '0;
                base_q[i] <= '0;
            end
            sel_q <= FALLBACK;
        end else begin
            st_q   <= st_d;
            mask_q <= mask_d;
            base_q <= base_d;
            sel_q  <= sel_d;
        end
    end

    always_comb begin
        nib = '0;
        for (int i = 0; i < NUM_DEV; i++)
            nib = nib | (bus.dev_nibble_in[4*i +: 4] & {4{sel_q[i]}});
    end

    assign bus.dev_sel    = sel_q;
    assign bus.nibble_out = nib;
    assign bus.daisy_out  = daisy;

`ifdef HP48_BUS_ERR_EN
    logic err_q, err_d;
    assign err_d = (bus.command == CMD_DP_WRITE && sel_oh[NC]) || (bus.command == CMD_CONFIG && daisy);
    always_ff @(posedge strobe or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign bus.bus_error = err_q;
`else
    assign bus.bus_error = 1'b0;
`endif
endmodule
